lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
// - Load/store initiator driving the byte-addressed data memory port (clk, wen, addr, wdata, rdata).
// - Accepts RV32I load/store requests from the pipeline; the memory always writes 4 bytes at addr..addr+3, so SB/SH use read-modify-write.
// - Returns sign/zero-extended load data or an error via a valid/ready response channel.
// PARAMETERS
// - MEM_BYTES  32  memory size in bytes; every access touches addr..addr+3
// PORTS
// - clk         in   1   clock, all state updates on posedge
// - rst_n       in   1   asynchronous active-low reset
// - req_valid   in   1   request present
// - req_ready   out  1   block can accept request (high only in IDLE)
// - req_store   in   1   1=store, 0=load
// - req_funct3  in   3   RV32I width/sign code
// - req_addr    in   32  byte address
// - req_wdata   in   32  store data, right-aligned
// - resp_valid  out  1   response present
// - resp_ready  in   1   consumer takes response
// - resp_rdata  out  32  extended load data; 0 for stores and errors
// - resp_err    out  1   illegal funct3 or out-of-range address
// - mem_wen     out  1   memory write enable
// - mem_addr    out  32  memory byte address
// - mem_wdata   out  32  memory write data
// - mem_rdata   in   32  combinational memory read data for mem_addr
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_addr=0, mem_wdata=0.
// - funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (load only); any other code, or BU/HU with store -> error.
// - Range: req_addr > MEM_BYTES-4 -> error; no memory access. Unaligned in-range accesses are legal.
// - FSM IDLE: req handshake (req_valid&req_ready) latches request; error -> RESP; load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
// - LOAD: mem_addr=latched addr; capture mem_rdata at edge; extend (B/H sign, BU/HU zero, W as-is) -> RESP.
// - RMW_RD: mem_addr=addr; merge: SB {rdata[31:8],wdata[7:0]}, SH {rdata[31:16],wdata[15:0]} -> WRITE.
// - WRITE: mem_wen=1 for exactly this one cycle with mem_addr/mem_wdata stable -> RESP.
// - RESP: resp_valid=1, outputs stable until resp_ready; on handshake -> IDLE (next request accepted only the following cycle).
// - mem_wen decoded from registered state only; never high outside WRITE.
// - mem_addr/mem_wdata hold last value in IDLE/RESP (no toggling required).
// - Latency from request edge to resp_valid: error 1, load 2, SW 2, SB/SH 3 cycles.
// - Reset mid-operation: transaction dropped, no response; reset in WRITE deasserts mem_wen before the edge -> no memory update.
// - req_* ignored outside IDLE; resp_ready ignored outside RESP.
// STRUCTURE
// - Package lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), FSM state enum {IDLE,LOAD,RMW_RD,WRITE,RESP}.
// - Sub-module lsu_data_align: combinational load extension and store merge (funct3, rdata, wdata -> ext_data, merged).
// - Top: FSM, request/response registers, range/legality check.
// TESTING (bench wraps the byte memory model, MEM_BYTES=32)
// - SW 0 @8, SW 0xDEADBEEF @4, LW @4 -> 0xDEADBEEF, err=0; mem_wen high exactly 1 cycle per store.
// - SB 0x5A @5 then LW @4 -> 0xDEAD5AEF; LW @8 -> 0x00000000 (RMW preserves neighbours).
// - Loads after above: LB @7 -> 0xFFFFFFDE, LBU @7 -> 0x000000DE, LH @6 -> 0xFFFFDEAD, LHU @6 -> 0x0000DEAD.
// - LW @28 -> ok; LW @29 and SB @31 -> err=1, rdata=0, mem_wen never asserted; funct3=011 -> err=1.
// - resp_ready low 3 cycles -> resp_valid/rdata/err stable, req_ready=0, no extra memory access.
// - rst_n low during WRITE cycle -> mem_wen 0 immediately, memory unchanged, all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM states and the request-legality helper for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    // Unsigned widths only make sense for loads.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response channel plus data-memory port of the load/store unit.
// slave = the controller, master = pipeline and memory side.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_data_align.sv
// Load sign/zero extension and SB/SH store merge into a 32-bit memory word.
// Purely combinational, no latency, no backpressure.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);

    always_comb begin
        ext_data = rdata;
        case (funct3)
            F3_B:    ext_data = {{24{rdata[7]}}, rdata[7:0]};
            F3_H:    ext_data = {{16{rdata[15]}}, rdata[15:0]};
            F3_BU:   ext_data = {24'd0, rdata[7:0]};
            F3_HU:   ext_data = {16'd0, rdata[15:0]};
            default: ext_data = rdata;
        endcase
    end

    always_comb begin
        merged = wdata;
        case (funct3)
            F3_B:    merged = {rdata[31:8], wdata[7:0]};
            F3_H:    merged = {rdata[31:16], wdata[15:0]};
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store FSM driving a 4-byte-wide memory port; SB/SH read-modify-write.
// Latency err 1 / load 2 / SW 2 / SB,SH 3 cycles; one request in flight, req_ready low until resp handshake.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);

    localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

    state_t      state;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_wen_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] ext_data;
    logic [31:0] merged;
    logic        req_err;

    assign req_err = !f3_legal(bus.req_store, bus.req_funct3) || (bus.req_addr > ADDR_MAX);

    lsu_data_align u_align (
        .funct3   (f3_q),
        .rdata    (bus.mem_rdata),
        .wdata    (wdata_q),
        .ext_data (ext_data),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            f3_q         <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        f3_q        <= bus.req_funct3;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= RESP;
                        end else begin
                            mem_addr_q <= bus.req_addr;
                            if (!bus.req_store) begin
                                state <= LOAD;
                            end else if (bus.req_funct3 == F3_W) begin
                                mem_wdata_q <= bus.req_wdata;
                                mem_wen_q   <= 1'b1;
                                state       <= WRITE;
                            end else begin
                                state <= RMW_RD;
                            end
                        end
                    end
                end
                LOAD: begin
                    resp_rdata_q <= ext_data;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RMW_RD: begin
                    mem_wdata_q <= merged;
                    mem_wen_q   <= 1'b1;
                    state       <= WRITE;
                end
                WRITE: begin
                    mem_wen_q    <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 32-byte little-endian memory model.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wen_total = 0;

    lsu_mem_ctrl_if ifc ();

    lsu_mem_ctrl #(.MEM_BYTES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [32];
    logic [4:0] ma;
    assign ma = ifc.mem_addr[4:0];
    assign ifc.mem_rdata = {mem[ma + 5'd3], mem[ma + 5'd2], mem[ma + 5'd1], mem[ma]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
        end else if (ifc.mem_wen) begin
            for (int k = 0; k < 4; k++) mem[ma + 5'(k)] <= ifc.mem_wdata[8*k +: 8];
        end
    end

    always @(posedge clk) if (ifc.mem_wen) wen_total <= wen_total + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge in IDLE; returns response fields, latency and write-enable cycles.
    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int wen_cnt);
        int n;
        n = 0;
        while (!ifc.req_ready && n < 20) begin @(negedge clk); n++; end
        ifc.req_valid  = 1'b1;
        ifc.req_store  = st;
        ifc.req_funct3 = f3;
        ifc.req_addr   = a;
        ifc.req_wdata  = wd;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        lat = 1;
        wen_cnt = 0;
        while (!ifc.resp_valid && lat < 20) begin
            if (ifc.mem_wen) wen_cnt++;
            @(negedge clk);
            lat++;
        end
        rd = ifc.resp_rdata;
        er = ifc.resp_err;
        ifc.resp_ready = 1'b1;
        @(negedge clk);
        ifc.resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wc;
    int          w0;
    int          n;
    logic [31:0] rd0;
    logic [31:0] a0;

    initial begin
        ifc.req_valid  = 1'b0;
        ifc.req_store  = 1'b0;
        ifc.req_funct3 = 3'b000;
        ifc.req_addr   = '0;
        ifc.req_wdata  = '0;
        ifc.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        chk("rst_resp_rdata", ifc.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(ifc.resp_err), 32'd0);
        chk("rst_mem_wen", 32'(ifc.mem_wen), 32'd0);
        chk("rst_mem_addr", ifc.mem_addr, 32'd0);
        chk("rst_mem_wdata", ifc.mem_wdata, 32'd0);
        rst_n = 1'b1;
        mem_clr = 1'b0;
        @(negedge clk);

        txn(1'b1, F3_W, 32'd8, 32'h0000_0000, rd, er, lat, wc);
        chk("sw8_lat", 32'(lat), 32'd2);
        chk("sw8_wen", 32'(wc), 32'd1);
        chk("sw8_err", 32'(er), 32'd0);
        chk("sw8_rdata", rd, 32'd0);
        txn(1'b1, F3_W, 32'd4, 32'hDEAD_BEEF, rd, er, lat, wc);
        chk("sw4_wen", 32'(wc), 32'd1);
        txn(1'b0, F3_W, 32'd4, 32'h0, rd, er, lat, wc);
        chk("lw4_data", rd, 32'hDEAD_BEEF);
        chk("lw4_err", 32'(er), 32'd0);
        chk("lw4_lat", 32'(lat), 32'd2);
        chk("lw4_wen", 32'(wc), 32'd0);

        txn(1'b1, F3_B, 32'd5, 32'h1234_565A, rd, er, lat, wc);
        chk("sb5_lat", 32'(lat), 32'd3);
        chk("sb5_wen", 32'(wc), 32'd1);
        chk("sb5_err", 32'(er), 32'd0);
        txn(1'b0, F3_W, 32'd4, 32'h0, rd, er, lat, wc);
        chk("lw4_after_sb", rd, 32'hDEAD_5AEF);
        txn(1'b0, F3_W, 32'd8, 32'h0, rd, er, lat, wc);
        chk("lw8_after_sb", rd, 32'h0000_0000);

        txn(1'b0, F3_B, 32'd7, 32'h0, rd, er, lat, wc);
        chk("lb7", rd, 32'hFFFF_FFDE);
        txn(1'b0, F3_BU, 32'd7, 32'h0, rd, er, lat, wc);
        chk("lbu7", rd, 32'h0000_00DE);
        txn(1'b0, F3_H, 32'd6, 32'h0, rd, er, lat, wc);
        chk("lh6", rd, 32'hFFFF_DEAD);
        txn(1'b0, F3_HU, 32'd6, 32'h0, rd, er, lat, wc);
        chk("lhu6", rd, 32'h0000_DEAD);

        txn(1'b1, F3_H, 32'd28, 32'hAAAA_1234, rd, er, lat, wc);
        chk("sh28_lat", 32'(lat), 32'd3);
        txn(1'b0, F3_W, 32'd28, 32'h0, rd, er, lat, wc);
        chk("lw28_data", rd, 32'h0000_1234);
        chk("lw28_err", 32'(er), 32'd0);

        w0 = wen_total;
        txn(1'b0, F3_W, 32'd29, 32'h0, rd, er, lat, wc);
        chk("lw29_err", 32'(er), 32'd1);
        chk("lw29_rdata", rd, 32'd0);
        chk("lw29_lat", 32'(lat), 32'd1);
        txn(1'b1, F3_B, 32'd31, 32'hFF, rd, er, lat, wc);
        chk("sb31_err", 32'(er), 32'd1);
        chk("sb31_rdata", rd, 32'd0);
        txn(1'b0, 3'b011, 32'd0, 32'h0, rd, er, lat, wc);
        chk("f3_011_err", 32'(er), 32'd1);
        txn(1'b1, F3_BU, 32'd0, 32'h77, rd, er, lat, wc);
        chk("sbu_err", 32'(er), 32'd1);
        chk("err_no_wen", 32'(wen_total), 32'(w0));
        txn(1'b0, F3_W, 32'd0, 32'h0, rd, er, lat, wc);
        chk("lw0_untouched", rd, 32'd0);

        // Response held off for 3 cycles while a stray store is presented.
        ifc.req_valid  = 1'b1;
        ifc.req_store  = 1'b0;
        ifc.req_funct3 = F3_W;
        ifc.req_addr   = 32'd4;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        n = 1;
        while (!ifc.resp_valid && n < 20) begin @(negedge clk); n++; end
        rd0 = ifc.resp_rdata;
        chk("bp_first_data", rd0, 32'hDEAD_5AEF);
        w0 = wen_total;
        a0 = ifc.mem_addr;
        ifc.req_valid  = 1'b1;
        ifc.req_store  = 1'b1;
        ifc.req_addr   = 32'd0;
        ifc.req_wdata  = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(ifc.resp_valid), 32'd1);
            chk("bp_resp_rdata", ifc.resp_rdata, 32'hDEAD_5AEF);
            chk("bp_resp_err", 32'(ifc.resp_err), 32'd0);
            chk("bp_req_ready", 32'(ifc.req_ready), 32'd0);
        end
        chk("bp_no_wen", 32'(wen_total), 32'(w0));
        chk("bp_mem_addr", ifc.mem_addr, a0);
        ifc.req_valid = 1'b0;
        ifc.resp_ready = 1'b1;
        @(negedge clk);
        ifc.resp_ready = 1'b0;
        chk("bp_done_valid", 32'(ifc.resp_valid), 32'd0);
        chk("bp_done_ready", 32'(ifc.req_ready), 32'd1);
        txn(1'b0, F3_W, 32'd0, 32'h0, rd, er, lat, wc);
        chk("bp_stray_ignored", rd, 32'd0);

        // Reset asserted while the store's write cycle is active.
        ifc.req_valid  = 1'b1;
        ifc.req_store  = 1'b1;
        ifc.req_funct3 = F3_W;
        ifc.req_addr   = 32'd12;
        ifc.req_wdata  = 32'hCAFE_F00D;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        chk("rw_wen_high", 32'(ifc.mem_wen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_wen_low", 32'(ifc.mem_wen), 32'd0);
        chk("rw_req_ready", 32'(ifc.req_ready), 32'd1);
        chk("rw_resp_valid", 32'(ifc.resp_valid), 32'd0);
        chk("rw_resp_rdata", ifc.resp_rdata, 32'd0);
        chk("rw_resp_err", 32'(ifc.resp_err), 32'd0);
        chk("rw_mem_addr", ifc.mem_addr, 32'd0);
        chk("rw_mem_wdata", ifc.mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rw_no_resp", 32'(ifc.resp_valid), 32'd0);
        txn(1'b0, F3_W, 32'd12, 32'h0, rd, er, lat, wc);
        chk("rw_mem_unchanged", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
